// File: rtl/div_arbiter_if.sv
// div_arbiter_if: request/response channels of two requesters plus the shared divider port.
interface div_arbiter_if #(parameter int WIDTH = 4);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic resp0_valid, resp0_ready, resp0_err, resp1_valid, resp1_ready, resp1_err;
  logic [WIDTH-1:0] resp0_q, resp0_r, resp1_q, resp1_r;
  logic [WIDTH-1:0] div_a, div_b, div_q, div_r;
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output resp0_ready, resp1_ready, div_q, div_r,
    input  req0_ready, req1_ready, resp0_valid, resp0_q, resp0_r, resp0_err,
    input  resp1_valid, resp1_q, resp1_r, resp1_err, div_a, div_b
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  resp0_ready, resp1_ready, div_q, div_r,
    output req0_ready, req1_ready, resp0_valid, resp0_q, resp0_r, resp0_err,
    output resp1_valid, resp1_q, resp1_r, resp1_err, div_a, div_b
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one combinational divider between two requesters.
module div_arbiter #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  div_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state;
  logic owner, prio, res_err, grant, accept, done;
  logic [WIDTH-1:0] op_a, op_b, res_q, res_r, sel_a, sel_b;
  always_comb begin
    grant = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    accept = state == IDLE && (bus.req0_valid || bus.req1_valid);
    sel_a = grant ? bus.req1_a : bus.req0_a;
    sel_b = grant ? bus.req1_b : bus.req0_b;
    done = owner ? bus.resp1_ready : bus.resp0_ready;
  end
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign bus.resp0_valid = state == RESP && !owner;
  assign bus.resp1_valid = state == RESP && owner;
  assign bus.resp0_q = res_q;
  assign bus.resp1_q = res_q;
  assign bus.resp0_r = res_r;
  assign bus.resp1_r = res_r;
  assign bus.resp0_err = res_err;
  assign bus.resp1_err = res_err;
  assign bus.div_a = op_a;
  assign bus.div_b = op_b;
  // Divide-by-zero skips CALC and leaves the divider operands untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      prio <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      res_q <= '0;
      res_r <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner <= grant;
          if (sel_b == '0) begin
            res_err <= 1'b1;
            res_q <= '1;
            res_r <= sel_a;
            state <= RESP;
          end else begin
            op_a <= sel_a;
            op_b <= sel_b;
            state <= CALC;
          end
        end
        CALC: begin
          res_q <= bus.div_q;
          res_r <= bus.div_r;
          res_err <= 1'b0;
          state <= RESP;
        end
        RESP: if (done) begin
          prio <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed and random stimulus against a transaction-level model of the arbiter.
module tb_div_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, passes = 0;
  div_arbiter_if #(.WIDTH(4)) bus();
  div_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.div_q = (bus.div_b == 4'd0) ? 4'hF : bus.div_a / bus.div_b;
    bus.div_r = (bus.div_b == 4'd0) ? bus.div_a : bus.div_a % bus.div_b;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // Transaction model: one outstanding job, a countdown to its response, and the favoured requester.
  bit m_busy = 0, m_prio = 0, m_owner = 0, m_err = 0;
  int m_wait = 0;
  logic [3:0] m_q = 0, m_r = 0, m_da = 0, m_db = 0, ma, mb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_prio = 0; m_owner = 0; m_da = 0; m_db = 0; m_wait = 0;
    end else if (!m_busy) begin
      if (bus.req0_valid || bus.req1_valid) begin
        m_owner = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
        ma = m_owner ? bus.req1_a : bus.req0_a;
        mb = m_owner ? bus.req1_b : bus.req0_b;
        m_busy = 1;
        if (mb == 0) begin
          m_err = 1; m_q = 4'hF; m_r = ma; m_wait = 0;
        end else begin
          m_err = 0; m_q = ma / mb; m_r = ma % mb; m_wait = 1; m_da = ma; m_db = mb;
        end
      end
    end else if (m_wait > 0) m_wait--;
    else if (m_owner ? bus.resp1_ready : bus.resp0_ready) begin
      m_busy = 0; m_prio = !m_owner;
    end
  end
  bit g, e0, e1, ev0, ev1;
  always @(negedge clk) if (!rst) begin
    g = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
    e0 = !m_busy && bus.req0_valid && !g;
    e1 = !m_busy && bus.req1_valid && g;
    ev0 = m_busy && m_wait == 0 && !m_owner;
    ev1 = m_busy && m_wait == 0 && m_owner;
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    chk("resp0_valid", bus.resp0_valid, ev0);
    chk("resp1_valid", bus.resp1_valid, ev1);
    chk("div_a", bus.div_a, m_da);
    chk("div_b", bus.div_b, m_db);
    if ((ev0 && bus.resp0_valid) || (ev1 && bus.resp1_valid)) begin
      chk("resp_q", ev0 ? bus.resp0_q : bus.resp1_q, m_q);
      chk("resp_r", ev0 ? bus.resp0_r : bus.resp1_r, m_r);
      chk("resp_err", ev0 ? bus.resp0_err : bus.resp1_err, m_err);
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send(input int n, input logic [3:0] a, input logic [3:0] b);
    bit got = 0;
    if (n == 1) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; end
    else begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (n == 1) ? bus.req1_ready : bus.req0_ready;
      tick();
    end
    if (!got) chk("accept_timeout", 0, 1);
    if (n == 1) bus.req1_valid = 0; else bus.req0_valid = 0;
  endtask
  task automatic recv(input int n, input int stall, output logic [3:0] q, output logic [3:0] r,
                      output logic e, output int lat);
    bit got = 0;
    q = 0; r = 0; e = 0; lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (n == 1 ? bus.resp1_valid : bus.resp0_valid) begin got = 1; lat = i; end
    end
    if (!got) begin chk("resp_timeout", 0, 1); return; end
    q = n == 1 ? bus.resp1_q : bus.resp0_q;
    r = n == 1 ? bus.resp1_r : bus.resp0_r;
    e = n == 1 ? bus.resp1_err : bus.resp0_err;
    for (int i = 0; i < stall; i++) begin
      tick();
      @(negedge clk);
      chk("stall_valid", n == 1 ? bus.resp1_valid : bus.resp0_valid, 1);
      chk("stall_q", n == 1 ? bus.resp1_q : bus.resp0_q, q);
      chk("stall_r", n == 1 ? bus.resp1_r : bus.resp0_r, r);
      chk("stall_no_ready", bus.req0_ready | bus.req1_ready, 0);
    end
    if (n == 1) bus.resp1_ready = 1; else bus.resp0_ready = 1;
    tick();
    bus.resp0_ready = 0; bus.resp1_ready = 0;
  endtask
  logic [3:0] q, r;
  logic e;
  int lat;
  int grants[$];
  int resps[$];
  bit a0, a1;
  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0; bus.resp0_ready = 0; bus.resp1_ready = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", bus.resp0_valid | bus.resp1_valid, 0);
    chk("rst_div", {bus.div_a, bus.div_b}, 0);
    chk("rst_ready", bus.req0_ready | bus.req1_ready, 0);
    tick(); rst = 0;
    send(0, 4'd13, 4'd4);
    recv(0, 2, q, r, e, lat);
    chk("single_q", q, 3); chk("single_r", r, 1); chk("single_err", e, 0); chk("single_lat", lat, 2);
    send(1, 4'd9, 4'd0);
    recv(1, 0, q, r, e, lat);
    chk("dz_q", q, 15); chk("dz_r", r, 9); chk("dz_err", e, 1); chk("dz_lat", lat, 1);
    chk("dz_div_a", bus.div_a, 13); chk("dz_div_b", bus.div_b, 4);
    send(0, 4'd13, 4'd5);
    bus.req1_valid = 1; bus.req1_a = 7; bus.req1_b = 3;
    recv(0, 5, q, r, e, lat);
    chk("bp_q", q, 2); chk("bp_r", r, 3);
    @(negedge clk);
    chk("bp_req1_next", bus.req1_ready, 1);
    tick(); bus.req1_valid = 0;
    recv(1, 0, q, r, e, lat);
    chk("bp1_q", q, 2); chk("bp1_r", r, 1); chk("bp1_lat", lat, 2);
    rst = 1; tick(); rst = 0;
    bus.req0_valid = 1; bus.req0_a = 15; bus.req0_b = 2;
    bus.req1_valid = 1; bus.req1_a = 7; bus.req1_b = 3;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("both_ready", bus.req0_ready & bus.req1_ready, 0);
      if (bus.req0_ready) grants.push_back(0);
      if (bus.req1_ready) grants.push_back(1);
      if (bus.resp0_valid) resps.push_back({4'd0, bus.resp0_q, bus.resp0_r});
      if (bus.resp1_valid) resps.push_back({4'd1, bus.resp1_q, bus.resp1_r});
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (3) tick();
    bus.resp0_ready = 0; bus.resp1_ready = 0;
    chk("grant_count", grants.size(), 4);
    chk("resp_count", resps.size(), 4);
    for (int i = 0; i < 4 && i < grants.size() && i < resps.size(); i++) begin
      chk("grant_order", grants[i], i % 2);
      chk("resp_order", resps[i], (i % 2) ? 12'h121 : 12'h071);
    end
    send(0, 4'd11, 4'd3);
    #2 rst = 1;
    #1 chk("mid_rst_valid", bus.resp0_valid | bus.resp1_valid, 0);
    chk("mid_rst_div", {bus.div_a, bus.div_b}, 0);
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1 chk("mid_rst_ready0", bus.req0_ready, 1);
    chk("mid_rst_ready1", bus.req1_ready, 0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick(); rst = 0;
    repeat (4) begin @(negedge clk); chk("abandoned", bus.resp0_valid | bus.resp1_valid, 0); tick(); end
    for (int n = 0; n < 2; n++)
      for (int a = 0; a < 16; a++)
        for (int b = 1; b < 16; b++) begin
          send(n, 4'(a), 4'(b));
          recv(n, 0, q, r, e, lat);
          chk("exh_q", q, a / b); chk("exh_r", r, a % b);
        end
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      tick();
      if (a0) bus.req0_valid = 0;
      if (a1) bus.req1_valid = 0;
      if (!bus.req0_valid && $urandom_range(1) == 1) begin
        bus.req0_valid = 1; bus.req0_a = 4'($urandom); bus.req0_b = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom);
      end
      if (!bus.req1_valid && $urandom_range(1) == 1) begin
        bus.req1_valid = 1; bus.req1_a = 4'($urandom); bus.req1_b = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom);
      end
      bus.resp0_ready = 1'($urandom);
      bus.resp1_ready = 1'($urandom);
    end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.resp0_ready = 1; bus.resp1_ready = 1;
    repeat (6) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
